// File: rtl/ex_pkg.sv
// ex_pkg: function codes, mul/div FSM states and decode helper for the execute stage.
package ex_pkg;
    localparam logic [5:0] FN_ADD  = 6'h00, FN_SUB = 6'h01, FN_AND = 6'h02, FN_OR  = 6'h03,
                           FN_XOR  = 6'h04, FN_SLL = 6'h05, FN_SRL = 6'h06, FN_SRA = 6'h07,
                           FN_SLT  = 6'h08, FN_SLTU = 6'h09;
    localparam logic [5:0] FN_MULS = 6'h0e, FN_MULU = 6'h16, FN_DIVS = 6'h0f, FN_DIVU = 6'h17;
    typedef enum logic [1:0] {IDLE, RUN, DONE} md_state_t;
    function automatic logic is_md(input logic [5:0] fn);
        return fn inside {FN_MULS, FN_MULU, FN_DIVS, FN_DIVU};
    endfunction
endpackage

// File: rtl/execute_md_if.sv
// execute_md_if: decode-side inputs, forwarding sources and EX/MEM outputs of the execute stage.
interface execute_md_if #(parameter int XLEN = 32, REGW = 5, CTRLW = 9);
    logic             in_valid, reg_lock, flush;
    logic [CTRLW-1:0] ctrl;
    logic [5:0]       alu_ctrl;
    logic [XLEN-1:0]  busA, busB, imm_ext;
    logic [2:0]       dmem_info;
    logic [REGW-1:0]  regA, regB, write_reg;
    logic [REGW-1:0]  write_reg_mem, write_reg_wb;
    logic [XLEN-1:0]  write_val_mem, write_val_wb;
    logic             reg_write_mem, reg_write_wb;
    logic             stall, md_busy, valid_reg;
    logic [CTRLW-1:0] ctrl_reg;
    logic [5:0]       alu_ctrl_reg;
    logic [XLEN-1:0]  result_reg, hi_reg, write_data_reg;
    logic [2:0]       dmem_info_reg;
    logic [REGW-1:0]  write_reg_reg;
    modport master (
        output in_valid, reg_lock, flush, ctrl, alu_ctrl, busA, busB, imm_ext, dmem_info,
               regA, regB, write_reg, write_reg_mem, write_val_mem, reg_write_mem,
               write_reg_wb, write_val_wb, reg_write_wb,
        input  stall, md_busy, valid_reg, ctrl_reg, alu_ctrl_reg, result_reg, hi_reg,
               write_data_reg, dmem_info_reg, write_reg_reg
    );
    modport slave (
        input  in_valid, reg_lock, flush, ctrl, alu_ctrl, busA, busB, imm_ext, dmem_info,
               regA, regB, write_reg, write_reg_mem, write_val_mem, reg_write_mem,
               write_reg_wb, write_val_wb, reg_write_wb,
        output stall, md_busy, valid_reg, ctrl_reg, alu_ctrl_reg, result_reg, hi_reg,
               write_data_reg, dmem_info_reg, write_reg_reg
    );
endinterface

// File: rtl/alu.sv
// alu: single-cycle combinational integer unit.
module alu import ex_pkg::*; #(parameter int XLEN = 32) (
    input  logic [5:0]      fn,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);
    localparam int SW = $clog2(XLEN);
    logic [SW-1:0] sh;
    assign sh = b[SW-1:0];
    always_comb begin
        case (fn)
            FN_ADD:  y = a + b;
            FN_SUB:  y = a - b;
            FN_AND:  y = a & b;
            FN_OR:   y = a | b;
            FN_XOR:  y = a ^ b;
            FN_SLL:  y = a << sh;
            FN_SRL:  y = a >> sh;
            FN_SRA:  y = XLEN'($signed(a) >>> sh);
            FN_SLT:  y = XLEN'($signed(a) < $signed(b));
            FN_SLTU: y = XLEN'(a < b);
            default: y = '0;
        endcase
    end
endmodule

// File: rtl/iter_muldiv.sv
// iter_muldiv: one-bit-per-cycle shift-add multiplier / restoring divider on operand magnitudes,
// with sign correction applied combinationally once the FSM reaches DONE.
module iter_muldiv import ex_pkg::*; #(parameter int XLEN = 32) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic            hold,
    input  logic [5:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] lo,
    output logic [XLEN-1:0] hi
);
    localparam int CW = $clog2(XLEN);
    md_state_t         state, state_nx;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   acc, mq, mb;
    logic              sa, sb, div, sgn, go, last;
    logic [XLEN:0]     sum, trial;
    logic [2*XLEN-1:0] prod;
    assign sgn   = op inside {FN_MULS, FN_DIVS};
    assign go    = state == IDLE && start && !flush;
    assign last  = cnt == CW'(XLEN - 1);
    assign busy  = state != IDLE;
    assign stall = go || state == RUN;
    assign done  = state == DONE;
    assign sum   = {1'b0, acc} + {1'b0, (mq[0] ? mb : {XLEN{1'b0}})};
    assign trial = {acc, mq[XLEN-1]} - {1'b0, mb};
    assign prod  = (sa ^ sb) ? -{acc, mq} : {acc, mq};
    // a zero divisor keeps the all-ones quotient regardless of the dividend's sign
    assign lo = div ? ((sa ^ sb) && mb != '0 ? -mq : mq) : prod[XLEN-1:0];
    assign hi = div ? (sa ? -acc : acc) : prod[2*XLEN-1:XLEN];
    always_comb begin
        state_nx = state;
        if (flush) state_nx = IDLE;
        else if (go) state_nx = RUN;
        else if (state == RUN && last) state_nx = DONE;
        else if (done && !hold) state_nx = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            mq    <= '0;
            mb    <= '0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            div   <= 1'b0;
        end else begin
            state <= state_nx;
            if (go) begin
                sa  <= sgn && a[XLEN-1];
                sb  <= sgn && b[XLEN-1];
                mq  <= sgn && a[XLEN-1] ? -a : a;
                mb  <= sgn && b[XLEN-1] ? -b : b;
                div <= op inside {FN_DIVS, FN_DIVU};
                acc <= '0;
                cnt <= '0;
            end else if (state == RUN) begin
                cnt <= cnt + 1'b1;
                if (div) begin
                    acc <= trial[XLEN] ? {acc[XLEN-2:0], mq[XLEN-1]} : trial[XLEN-1:0];
                    mq  <= {mq[XLEN-2:0], !trial[XLEN]};
                end else begin
                    {acc, mq} <= {sum, mq[XLEN-1:1]};
                end
            end
        end
    end
endmodule

// File: rtl/execute_md.sv
// execute_md: EX stage with MEM/WB forwarding, iterative mul/div with stall, and the EX/MEM register.
module execute_md import ex_pkg::*; #(parameter int XLEN = 32, REGW = 5, CTRLW = 9) (
    input logic         clk,
    input logic         rst_n,
    execute_md_if.slave s
);
    logic [XLEN-1:0] fwd_a, fwd_b, alu_b, alu_y, md_lo, md_hi;
    logic            md_done, bubble;
    assign fwd_a = s.regA != '0 && s.reg_write_mem && s.regA == s.write_reg_mem ? s.write_val_mem :
                   s.regA != '0 && s.reg_write_wb && s.regA == s.write_reg_wb ? s.write_val_wb : s.busA;
    assign fwd_b = s.regB != '0 && s.reg_write_mem && s.regB == s.write_reg_mem ? s.write_val_mem :
                   s.regB != '0 && s.reg_write_wb && s.regB == s.write_reg_wb ? s.write_val_wb : s.busB;
    assign alu_b  = s.ctrl[1] ? s.imm_ext : fwd_b;
    assign bubble = s.stall || s.flush;
    alu #(.XLEN(XLEN)) u_alu (.fn(s.alu_ctrl), .a(fwd_a), .b(alu_b), .y(alu_y));
    iter_muldiv #(.XLEN(XLEN)) u_md (
        .clk(clk), .rst_n(rst_n), .start(s.in_valid && is_md(s.alu_ctrl)), .flush(s.flush),
        .hold(s.reg_lock), .op(s.alu_ctrl), .a(fwd_a), .b(fwd_b), .busy(s.md_busy),
        .stall(s.stall), .done(md_done), .lo(md_lo), .hi(md_hi)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s.valid_reg      <= 1'b0;
            s.ctrl_reg       <= '0;
            s.alu_ctrl_reg   <= '0;
            s.result_reg     <= '0;
            s.hi_reg         <= '0;
            s.write_data_reg <= '0;
            s.dmem_info_reg  <= '0;
            s.write_reg_reg  <= '0;
        end else if (!s.reg_lock) begin
            s.valid_reg      <= s.in_valid && !bubble;
            s.ctrl_reg       <= bubble ? '0 : s.ctrl;
            s.alu_ctrl_reg   <= s.alu_ctrl;
            s.result_reg     <= md_done ? md_lo : alu_y;
            s.hi_reg         <= md_done ? md_hi : '0;
            s.write_data_reg <= fwd_b;
            s.dmem_info_reg  <= s.dmem_info;
            s.write_reg_reg  <= s.write_reg;
        end
    end
endmodule

// File: tb/tb_execute_md.sv
// tb_execute_md: randomized and directed checks of execute_md against an arithmetic reference model.
module tb_execute_md;
    import ex_pkg::*;
    localparam int XLEN = 32, REGW = 5, CTRLW = 9;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0, errors = 0;
    logic [5:0] alu_fns [10] = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_SLL, FN_SRL, FN_SRA, FN_SLT, FN_SLTU};
    logic [5:0] md_fns  [4]  = '{FN_MULS, FN_MULU, FN_DIVS, FN_DIVU};
    execute_md_if #(.XLEN(XLEN), .REGW(REGW), .CTRLW(CTRLW)) ex ();
    execute_md #(.XLEN(XLEN), .REGW(REGW), .CTRLW(CTRLW)) dut (.clk(clk), .rst_n(rst_n), .s(ex));
    always #5 clk = ~clk;
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic clear_inputs;
        ex.in_valid = 0; ex.reg_lock = 0; ex.flush = 0; ex.ctrl = '0; ex.alu_ctrl = FN_ADD;
        ex.busA = '0; ex.busB = '0; ex.imm_ext = '0; ex.dmem_info = '0;
        ex.regA = '0; ex.regB = '0; ex.write_reg = '0;
        ex.write_reg_mem = '0; ex.write_val_mem = '0; ex.reg_write_mem = 0;
        ex.write_reg_wb = '0; ex.write_val_wb = '0; ex.reg_write_wb = 0;
    endtask
    function automatic logic [31:0] fwd_ref(input logic [4:0] src, input logic [31:0] bus_val);
        if (src == 0) return bus_val;
        if (ex.reg_write_mem && src == ex.write_reg_mem) return ex.write_val_mem;
        if (ex.reg_write_wb && src == ex.write_reg_wb) return ex.write_val_wb;
        return bus_val;
    endfunction
    function automatic logic [31:0] alu_ref(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        case (fn)
            FN_ADD:  return a + b;
            FN_SUB:  return a - b;
            FN_AND:  return a & b;
            FN_OR:   return a | b;
            FN_XOR:  return a ^ b;
            FN_SLL:  return a << b[4:0];
            FN_SRL:  return a >> b[4:0];
            FN_SRA:  return 32'(int'(a) >>> b[4:0]);
            FN_SLT:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            FN_SLTU: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction
    function automatic logic [63:0] md_ref(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        case (fn)
            FN_MULS: return 64'(longint'(int'(a)) * longint'(int'(b)));
            FN_MULU: return {32'b0, a} * {32'b0, b};
            FN_DIVU: return b == 0 ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                return {32'(int'(a) % int'(b)), 32'(int'(a) / int'(b))};
            end
        endcase
    endfunction
    task automatic check_alu(input string tag);
        logic [31:0] eb = fwd_ref(ex.regB, ex.busB);
        logic [31:0] er = alu_ref(ex.alu_ctrl, fwd_ref(ex.regA, ex.busA), ex.ctrl[1] ? ex.imm_ext : eb);
        logic        ev = ex.in_valid && !ex.flush;
        logic [8:0]  ec = ex.flush ? 9'h0 : ex.ctrl;
        logic [4:0]  ew = ex.write_reg;
        logic [2:0]  ed = ex.dmem_info;
        logic [5:0]  ef = ex.alu_ctrl;
        tick;
        check({tag, ".result"}, ex.result_reg, er);
        check({tag, ".hi"}, ex.hi_reg, 0);
        check({tag, ".valid"}, ex.valid_reg, ev);
        check({tag, ".ctrl"}, ex.ctrl_reg, ec);
        check({tag, ".wdata"}, ex.write_data_reg, eb);
        check({tag, ".wreg"}, ex.write_reg_reg, ew);
        check({tag, ".dmem"}, ex.dmem_info_reg, ed);
        check({tag, ".fn"}, ex.alu_ctrl_reg, ef);
    endtask
    task automatic run_md(input string tag, input logic [5:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input int lock);
        logic [63:0] e = md_ref(fn, a, b);
        int n = 0;
        clear_inputs;
        ex.in_valid = 1; ex.alu_ctrl = fn; ex.busA = a; ex.busB = b;
        ex.ctrl = 9'h001; ex.write_reg = 5'd7; ex.dmem_info = 3'b101;
        #1;
        while (ex.stall && n < 100) begin
            tick;
            n++;
            if (n == 1) begin
                check({tag, ".bubble_valid"}, ex.valid_reg, 0);
                check({tag, ".bubble_ctrl"}, ex.ctrl_reg, 0);
            end
        end
        check({tag, ".stall_cycles"}, n, XLEN + 1);
        check({tag, ".busy_done"}, ex.md_busy, 1);
        repeat (lock) begin
            ex.reg_lock = 1;
            tick;
            check({tag, ".lock_busy"}, ex.md_busy, 1);
            check({tag, ".lock_stall"}, ex.stall, 0);
            check({tag, ".lock_valid"}, ex.valid_reg, 0);
        end
        ex.reg_lock = 0;
        tick;
        ex.in_valid = 0;
        ex.alu_ctrl = FN_ADD;
        check({tag, ".lo"}, ex.result_reg, e[31:0]);
        check({tag, ".hi"}, ex.hi_reg, e[63:32]);
        check({tag, ".valid"}, ex.valid_reg, 1);
        check({tag, ".ctrl"}, ex.ctrl_reg, 9'h001);
        check({tag, ".idle"}, ex.md_busy, 0);
    endtask
    initial begin
        rst_n = 1;
        clear_inputs;
        #2 rst_n = 0;
        #1;
        check("rst.valid", ex.valid_reg, 0);
        check("rst.ctrl", ex.ctrl_reg, 0);
        check("rst.result", ex.result_reg, 0);
        check("rst.hi", ex.hi_reg, 0);
        check("rst.wdata", ex.write_data_reg, 0);
        check("rst.stall", ex.stall, 0);
        check("rst.busy", ex.md_busy, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        tick;
        ex.in_valid = 1; ex.ctrl = 9'h001; ex.alu_ctrl = FN_ADD;
        ex.regA = 5'd3; ex.busA = 100; ex.busB = 20;
        ex.write_reg_mem = 5'd3; ex.write_val_mem = 5; ex.reg_write_mem = 1;
        ex.write_reg_wb = 5'd3; ex.write_val_wb = 9; ex.reg_write_wb = 1;
        check_alu("fwd_mem");
        check("fwd_mem_const", ex.result_reg, 25);
        ex.regA = 5'd0;
        check_alu("fwd_r0");
        check("fwd_r0_const", ex.result_reg, 120);
        for (int i = 0; i < 30; i++) begin
            ex.alu_ctrl = alu_fns[$urandom_range(0, 9)];
            ex.busA = $urandom; ex.busB = $urandom; ex.imm_ext = $urandom;
            ex.ctrl = 9'($urandom); ex.dmem_info = 3'($urandom);
            ex.regA = 5'($urandom_range(0, 3)); ex.regB = 5'($urandom_range(0, 3));
            ex.write_reg = 5'($urandom);
            ex.write_reg_mem = 5'($urandom_range(0, 3)); ex.write_val_mem = $urandom;
            ex.reg_write_mem = 1'($urandom);
            ex.write_reg_wb = 5'($urandom_range(0, 3)); ex.write_val_wb = $urandom;
            ex.reg_write_wb = 1'($urandom);
            ex.in_valid = 1'($urandom);
            ex.flush = $urandom_range(0, 7) == 0;
            check_alu("rand_alu");
        end
        run_md("muls", FN_MULS, -3, 7, 0);
        check("muls.lo_const", ex.result_reg, 32'hFFFF_FFEB);
        check("muls.hi_const", ex.hi_reg, 32'hFFFF_FFFF);
        run_md("divu", FN_DIVU, 100, 7, 0);
        check("divu.q_const", ex.result_reg, 14);
        check("divu.r_const", ex.hi_reg, 2);
        run_md("divs", FN_DIVS, -100, 7, 0);
        check("divs.q_const", ex.result_reg, 32'hFFFF_FFF2);
        check("divs.r_const", ex.hi_reg, 32'hFFFF_FFFE);
        run_md("divu0", FN_DIVU, 32'h1234_5678, 0, 0);
        run_md("divs0", FN_DIVS, 32'hFFFF_FF00, 0, 0);
        run_md("divs_ovf", FN_DIVS, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_md("mulu_max", FN_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_md("lock", FN_DIVS, 12345, -17, 3);
        for (int i = 0; i < 10; i++) begin
            logic [31:0] b = ($urandom_range(0, 4) == 0) ? 32'h0 : 32'($urandom);
            run_md("rand_md", md_fns[$urandom_range(0, 3)], $urandom, b, $urandom_range(0, 2));
        end
        clear_inputs;
        ex.in_valid = 1; ex.alu_ctrl = FN_MULS; ex.busA = 1234; ex.busB = 5678; ex.ctrl = 9'h001;
        #1;
        repeat (11) tick;
        check("flush.pre_stall", ex.stall, 1);
        ex.flush = 1;
        tick;
        ex.flush = 0;
        ex.in_valid = 0;
        #1;
        check("flush.busy", ex.md_busy, 0);
        check("flush.stall", ex.stall, 0);
        check("flush.valid", ex.valid_reg, 0);
        check("flush.ctrl", ex.ctrl_reg, 0);
        ex.in_valid = 1; ex.alu_ctrl = FN_ADD; ex.busA = 40; ex.busB = 2; ex.write_reg = 5'd9;
        check_alu("post_flush");
        check("post_flush_const", ex.result_reg, 42);
        clear_inputs;
        ex.in_valid = 1; ex.alu_ctrl = FN_DIVU; ex.busA = 1000; ex.busB = 3;
        ex.write_reg = 5'd7; ex.dmem_info = 3'b101;
        #1;
        repeat (6) tick;
        ex.in_valid = 0;
        #2;
        check("mid_rst.pre_busy", ex.md_busy, 1);
        rst_n = 0;
        #1;
        check("mid_rst.valid", ex.valid_reg, 0);
        check("mid_rst.ctrl", ex.ctrl_reg, 0);
        check("mid_rst.fn", ex.alu_ctrl_reg, 0);
        check("mid_rst.result", ex.result_reg, 0);
        check("mid_rst.hi", ex.hi_reg, 0);
        check("mid_rst.wdata", ex.write_data_reg, 0);
        check("mid_rst.dmem", ex.dmem_info_reg, 0);
        check("mid_rst.wreg", ex.write_reg_reg, 0);
        check("mid_rst.busy", ex.md_busy, 0);
        check("mid_rst.stall", ex.stall, 0);
        @(negedge clk) rst_n = 1;
        tick;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
